dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data SRAM between the CPU MEM stage and an external
// loader port. Grants are combinational from the current requests and the
// registered arbitration state:
//   - LAST: the requester that got the most recent grant
//   - RUN:  how many grants in a row LAST has received
// One requester gets a burst of up to MAX_BURST grants while the other waits.
// After that, the waiting requester is granted.
// A granted read registers a one-cycle tag (valid, owner). In the following
// cycle, the SRAM's registered read data is steered to the owning port.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   cpu_req/wen/addr/wdata   (in)     CPU access request and payload
//   cpu_gnt, cpu_stall       (out)    grant this cycle, pipeline stall
//   cpu_rvalid, cpu_rdata    (out)    read return, one cycle after grant
//   ext_req/wen/addr/wdata   (in)     external loader request and payload
//   ext_gnt, ext_rvalid, ext_rdata    external grant and read return
//   mem_en, mem_wen, mem_addr, mem_wdata (out)  SRAM access
//   mem_rdata                (in)     SRAM read data, one cycle after a read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  localparam logic [3:0] MAX_RUN = 4'(MAX_BURST);

  owner_e     r_last;
  logic [3:0] r_run;
  logic       r_tag_valid;
  owner_e     r_tag_owner;

  owner_e     w_last_nxt;
  logic [3:0] w_run_nxt;
  owner_e     w_pick;
  owner_e     w_gnt_owner;
  logic       w_cpu_gnt;
  logic       w_ext_gnt;
  logic       w_any_gnt;
  logic       w_gnt_wen;
  logic       w_rd_live;

  // Grant selection. Nothing is granted while reset is held.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the block
    // leaves it unassigned and no latch is inferred.
    w_cpu_gnt = 1'b0;
    w_ext_gnt = 1'b0;
    w_pick    = r_last;
    if (!rst) begin
      if (cpu_req && ext_req) begin
        // The burst owner keeps the memory until its run reaches the limit.
        // After that, the other requester is granted.
        if (r_run < MAX_RUN) begin
          w_pick = r_last;
        end else begin
          w_pick = (r_last == OWN_CPU) ? OWN_EXT : OWN_CPU;
        end
        w_cpu_gnt = (w_pick == OWN_CPU);
        w_ext_gnt = (w_pick == OWN_EXT);
      end else begin
        w_cpu_gnt = cpu_req;
        w_ext_gnt = ext_req;
      end
    end
  end

  assign w_any_gnt   = w_cpu_gnt | w_ext_gnt;
  assign w_gnt_owner = w_ext_gnt ? OWN_EXT : OWN_CPU;
  assign w_gnt_wen   = w_cpu_gnt ? cpu_wen : (w_ext_gnt ? ext_wen : 1'b0);

  // Next arbitration state.
  always_comb begin
    w_last_nxt = r_last;
    w_run_nxt  = r_run;
    if (w_any_gnt) begin
      if (w_gnt_owner == r_last) begin
        // RUN saturates at the limit. It does not wrap.
        w_run_nxt = (r_run >= MAX_RUN) ? MAX_RUN : r_run + 4'd1;
      end else begin
        w_last_nxt = w_gnt_owner;
        w_run_nxt  = 4'd1;
      end
    end else begin
      // With no request, the run is cleared but the owner is kept.
      w_run_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments. All registers then
    // update together from the values sampled at the edge.
    if (rst) begin
      r_last      <= OWN_CPU;
      r_run       <= 4'd0;
      r_tag_valid <= 1'b0;
      r_tag_owner <= OWN_CPU;
    end else begin
      r_last      <= w_last_nxt;
      r_run       <= w_run_nxt;
      r_tag_valid <= w_any_gnt & ~w_gnt_wen;
      r_tag_owner <= w_gnt_owner;
    end
  end

  // SRAM access, taken from the granted port. All fields are zero when idle.
  assign mem_en    = w_any_gnt;
  assign mem_wen   = w_gnt_wen;
  assign mem_addr  = w_cpu_gnt ? cpu_addr  : (w_ext_gnt ? ext_addr  : '0);
  assign mem_wdata = w_cpu_gnt ? cpu_wdata : (w_ext_gnt ? ext_wdata : '0);

  assign cpu_gnt   = w_cpu_gnt;
  assign ext_gnt   = w_ext_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;

  // A tag still held from the cycle before reset must not show up as a read
  // return while reset is asserted.
  assign w_rd_live  = r_tag_valid & ~rst;
  assign cpu_rvalid = w_rd_live & (r_tag_owner == OWN_CPU);
  assign ext_rvalid = w_rd_live & (r_tag_owner == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule
